// File: rtl/mesh_eject_port_if.sv
// Eject-side stream from the mesh sink to the local consumer.
// Each beat carries one flit's payload plus its packet boundary flags.
interface mesh_eject_port_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        head;
  logic        tail;

  modport master (output valid, data, head, tail, input ready);
  modport slave  (input valid, data, head, tail, output ready);
endinterface

// File: rtl/mesh_eject_port.sv
// Mesh sink: filters flits by destination, buffers accepted packets in a FIFO,
// and keeps delivery, drop and overflow statistics.
module mesh_eject_port #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] LOCAL_ID   = 4'b1010,
  parameter int         CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [33:0]          mesh_in,
  mesh_eject_port_if.master    eject,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [7:0]           drop_count,
  output logic                 ovf_err,
  output logic                 proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] PKT_ONE = 1;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [33:0] mem [FIFO_DEPTH];
  logic [33:0] rd_entry;

  logic        present, is_tail, dest_hit;
  logic        empty, full, pop, room, push;
  logic        push_req, push_head, pkt_inc, drop_inc, ovf_set;

  function automatic logic [CNT_W-1:0] sat_inc_pkt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + PKT_ONE;
  endfunction

  function automatic logic [7:0] sat_inc_drop(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  assign present  = mesh_in[33];
  assign is_tail  = mesh_in[32];
  assign dest_hit = (mesh_in[31:28] == LOCAL_ID);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = eject.valid & eject.ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign room  = ~full | pop;
  assign push  = push_req & room;

  assign rd_entry    = mem[rd_ptr[AW-1:0]];
  assign eject.valid = ~empty;
  assign eject.head  = eject.valid & rd_entry[33];
  assign eject.tail  = eject.valid & rd_entry[32];
  assign eject.data  = eject.valid ? rd_entry[31:0] : 32'd0;

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_head = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (present) begin
          if (dest_hit) begin
            push_req  = 1'b1;
            push_head = 1'b1;
            if (room) begin
              pkt_inc   = is_tail;
              state_nxt = is_tail ? IDLE : BODY;
            end else begin
              ovf_set   = 1'b1;
              drop_inc  = 1'b1;
              state_nxt = is_tail ? IDLE : DROP;
            end
          end else begin
            drop_inc  = 1'b1;
            state_nxt = is_tail ? IDLE : DROP;
          end
        end
      end
      BODY: begin
        if (present) begin
          push_req = 1'b1;
          if (room) begin
            pkt_inc   = is_tail;
            state_nxt = is_tail ? IDLE : BODY;
          end else begin
            ovf_set   = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = is_tail ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (present && is_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Payload storage carries no reset; visibility is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_head, is_tail, mesh_in[31:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
      ovf_err    <= 1'b0;
      proto_err  <= 1'b0;
    end else if (stat_clr) begin
      pkt_count  <= '0;
      drop_count <= '0;
      ovf_err    <= 1'b0;
      proto_err  <= present && (state != IDLE);
    end else begin
      if (pkt_inc)  pkt_count  <= sat_inc_pkt(pkt_count);
      if (drop_inc) drop_count <= sat_inc_drop(drop_count);
      if (ovf_set)  ovf_err    <= 1'b1;
    end
  end

endmodule
